// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle between a requester and the nibble-serial add/sub sequencer.
interface nibble_serial_add_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   modport master (
      output start, sub, cin, op_a, op_b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, sub, cin, op_a, op_b,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Time-shared add/subtract of 4*NIBBLES-bit operands through one 4-bit CLA slice,
// one nibble per cycle, LSB nibble first, carry chained through c_q.
module Adder (
   input  logic [3:0] be_add_number,
   input  logic [3:0] add_number,
   input  logic       Cin,
   output logic [3:0] sum,
   output logic       Cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = be_add_number & add_number;
      p    = be_add_number ^ add_number;
      c[0] = Cin;
      c[1] = g[0] | (p[0] & Cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & Cin);
      sum  = p ^ c[3:0];
      Cout = c[4];
   end
endmodule

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   nibble_serial_add_ctrl_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [IW-1:0] idx;
   logic          c_q;

   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [3:0]    s_nib;
   logic          c_nib;
   logic [W-1:0]  sum_nx;
   logic          ovf_nx;

   always_comb begin
      a_nib  = a_q[4*idx +: 4];
      b_nib  = b_q[4*idx +: 4];
      sum_nx = sum_q;
      sum_nx[4*idx +: 4] = s_nib;
      // b_q already holds the inverted operand in sub mode, so this is the b' sign.
      ovf_nx = (a_q[W-1] == b_q[W-1]) && (sum_nx[W-1] != a_q[W-1]);
   end

   Adder u_slice (
      .be_add_number (a_nib),
      .add_number    (b_nib),
      .Cin           (c_q),
      .sum           (s_nib),
      .Cout          (c_nib)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         idx          <= '0;
         c_q          <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.result   <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_q      <= bus.op_a;
                  b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
                  c_q      <= bus.sub | bus.cin;
                  idx      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state    <= IDLE;
               end
            end
            RUN: begin
               sum_q <= sum_nx;
               c_q   <= c_nib;
               if (idx == LAST) begin
                  idx          <= '0;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.result   <= sum_nx;
                  bus.cout     <= c_nib;
                  bus.overflow <= ovf_nx;
                  state        <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed checks of the nibble-serial add/sub sequencer with NIBBLES=4.
module tb_nibble_serial_add_ctrl;
   localparam int NIB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   nibble_serial_add_ctrl_if #(.NIBBLES(NIB)) bus ();

   nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.sub   = s;
      bus.cin   = ci;
   endtask

   // Called at a falling edge where start is to be presented; returns at the
   // falling edge inside the done cycle.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ci, input logic [15:0] er,
                         input logic ec, input logic eo);
      drive(a, b, s, ci);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= NIB; i++) begin
         chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
         chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, er});
      chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
      chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
   endtask

   initial begin
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_result", {16'd0, bus.result}, 32'd0);
      chk("rst_cout", {31'd0, bus.cout}, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
      @(negedge clk);
      chk("add_done_once", {31'd0, bus.done}, 32'd0);
      chk("add_hold", {16'd0, bus.result}, 32'h2201);

      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      run_op("cin", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      @(negedge clk);
      run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      @(negedge clk);
      run_op("borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      @(negedge clk);

      // start pulsed mid-RUN with new operands must be ignored
      drive(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign_old_result", {16'd0, bus.result}, 32'hFFFE);
      @(negedge clk);
      drive(16'hAAAA, 16'h5555, 1'b1, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("ign_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      chk("ign_done", {31'd0, bus.done}, 32'd1);
      chk("ign_result", {16'd0, bus.result}, 32'h3333);
      chk("ign_cout", {31'd0, bus.cout}, 32'd0);
      @(negedge clk);
      chk("ign_not_queued", {31'd0, bus.busy}, 32'd0);

      // back-to-back: start held through DONE of the previous op
      run_op("b2b_first", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      drive(16'h0001, 16'h0002, 1'b0, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_nogap", {31'd0, bus.busy}, 32'd1);
      chk("b2b_hold_prev", {16'd0, bus.result}, 32'h0100);
      repeat (NIB - 1) @(negedge clk);
      chk("b2b_last_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      chk("b2b_done", {31'd0, bus.done}, 32'd1);
      chk("b2b_result", {16'd0, bus.result}, 32'h0003);
      @(negedge clk);

      // reset dropped for one edge during RUN cycle 2
      drive(16'h4321, 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      chk("mid_rst_result", {16'd0, bus.result}, 32'd0);
      chk("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
      chk("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
      for (int i = 0; i < NIB + 2; i++) begin
         @(negedge clk);
         chk("mid_rst_no_done", {31'd0, bus.done}, 32'd0);
         chk("mid_rst_no_busy", {31'd0, bus.busy}, 32'd0);
      end
      run_op("after_rst", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
